// File: rtl/hazard_pkg.sv
// Shared encodings and helpers for the hazard / scoreboard unit.
package hazard_pkg;
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Saturating increment; callers zero-extend their counter and ceiling to 32 bits.
  function automatic logic [31:0] satInc(input logic [31:0] v, input logic [31:0] maxV,
                                         input logic inc);
    return (inc && v != maxV) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline-side bundle: register tags and enables in, forward/stall selects and debug state out.
interface hazard_scoreboard_unit_if #(parameter int NREG = 32, parameter int PERF_W = 16);
  localparam int AW = $clog2(NREG);
  logic [AW-1:0]     RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduDoneReg;
  logic              RegWriteD, RegWriteE, RegWriteM, RegWriteW;
  logic              MemtoRegE, MemtoRegM, BranchD, MduIssueD, MduDone;
  logic [1:0]        ForwardAE, ForwardBE;
  logic              ForwardAD, ForwardBD, StallF, StallD, FlushE;
  logic [NREG-1:0]   Pending;
  logic [PERF_W-1:0] StallCnt, MduStallCnt;

  modport master (
    output RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduDoneReg,
           RegWriteD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduIssueD, MduDone,
    input  ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE,
           Pending, StallCnt, MduStallCnt
  );
  modport slave (
    input  RsD, RtD, WriteRegD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW, MduDoneReg,
           RegWriteD, RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MemtoRegM, BranchD,
           MduIssueD, MduDone,
    output ForwardAE, ForwardBE, ForwardAD, ForwardBD, StallF, StallD, FlushE,
           Pending, StallCnt, MduStallCnt
  );
endinterface

// File: rtl/hazard_scoreboard_unit_mdu_scoreboard.sv
// Pending-destination bitmap and outstanding-write count for long-latency MDU results.
module mdu_scoreboard #(
  parameter int NREG    = 32,
  parameter int MDU_MAX = 4,
  parameter int AW      = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            setEn,
  input  logic [AW-1:0]   setReg,
  input  logic            clrEn,
  input  logic [AW-1:0]   clrReg,
  output logic [NREG-1:0] pending,
  output logic            full
);
  localparam int CW = $clog2(MDU_MAX + 1);

  logic [CW-1:0]   count, countNext;
  logic [NREG-1:0] pendNext;
  logic            doSet, validClr;
  int              cTmp;

  always_comb begin
    doSet    = setEn && setReg != '0;
    validClr = clrEn && pending[clrReg];
    pendNext = pending;
    // Clear first so a same-register set in the same cycle leaves the bit set.
    if (validClr) pendNext[clrReg] = 1'b0;
    if (doSet)    pendNext[setReg] = 1'b1;
    cTmp = int'(count) + int'(doSet) - int'(validClr);
    if (cTmp < 0)       cTmp = 0;
    if (cTmp > MDU_MAX) cTmp = MDU_MAX;
    countNext = CW'(cTmp);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending <= '0;
      count   <= '0;
    end else begin
      pending <= pendNext;
      count   <= countNext;
    end
  end

  assign full = (count == CW'(MDU_MAX));
endmodule

// File: rtl/hazard_scoreboard_unit.sv
// 5-stage MIPS hazard unit: ALU/branch forwarding, load-use and branch interlocks,
// MDU scoreboard interlocks (RAW, WAW, capacity) and saturating stall counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int NREG    = 32,
  parameter int MDU_MAX = 4,
  parameter int PERF_W  = 16
) (
  input logic                     clk,
  input logic                     reset,
  hazard_scoreboard_unit_if.slave hz
);
  localparam int AW = $clog2(NREG);
  localparam logic [PERF_W-1:0] PERF_MAX = '1;

  logic [1:0][AW-1:0] srcE, srcD;
  logic [1:0][1:0]    fwdE;
  logic [1:0]         fwdD;
  logic [NREG-1:0]    pending;
  logic               full, lwStall, brStall, sbStall, stall;
  logic [PERF_W-1:0]  stallCnt, mduStallCnt;

  assign srcE = {hz.RtE, hz.RsE};
  assign srcD = {hz.RtD, hz.RsD};

  for (genvar i = 0; i < 2; i++) begin : g_fwd
    logic hitM, hitW;
    assign hitM    = srcE[i] != '0 && srcE[i] == hz.WriteRegM && hz.RegWriteM;
    assign hitW    = srcE[i] != '0 && srcE[i] == hz.WriteRegW && hz.RegWriteW;
    assign fwdE[i] = hitM ? FWD_MEM : (hitW ? FWD_WB : FWD_RF);
    assign fwdD[i] = srcD[i] != '0 && srcD[i] == hz.WriteRegM && hz.RegWriteM;
  end

  assign hz.ForwardAE = fwdE[0];
  assign hz.ForwardBE = fwdE[1];
  assign hz.ForwardAD = fwdD[0];
  assign hz.ForwardBD = fwdD[1];

  // A register retiring from the MDU this cycle is readable through the regfile write-first path.
  function automatic logic sbHit(input logic [AW-1:0] r);
    return r != '0 && pending[r] && !(hz.MduDone && hz.MduDoneReg == r);
  endfunction

  always_comb begin
    lwStall = hz.MemtoRegE && hz.RtE != '0 && (hz.RsD == hz.RtE || hz.RtD == hz.RtE);
    brStall = hz.BranchD &&
      ((hz.RegWriteE && hz.WriteRegE != '0 && (hz.WriteRegE == hz.RsD || hz.WriteRegE == hz.RtD)) ||
       (hz.MemtoRegM && hz.WriteRegM != '0 && (hz.WriteRegM == hz.RsD || hz.WriteRegM == hz.RtD)));
    sbStall = sbHit(hz.RsD) || sbHit(hz.RtD) || (hz.RegWriteD && sbHit(hz.WriteRegD)) ||
              (hz.MduIssueD && full && !hz.MduDone);
    stall   = lwStall || brStall || sbStall;
  end

  assign hz.StallF = stall;
  assign hz.StallD = stall;
  assign hz.FlushE = stall;

  mdu_scoreboard #(.NREG(NREG), .MDU_MAX(MDU_MAX), .AW(AW)) u_sb (
    .clk    (clk),
    .reset  (reset),
    .setEn  (hz.MduIssueD && !stall),
    .setReg (hz.WriteRegD),
    .clrEn  (hz.MduDone),
    .clrReg (hz.MduDoneReg),
    .pending(pending),
    .full   (full)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCnt    <= '0;
      mduStallCnt <= '0;
    end else begin
      stallCnt    <= PERF_W'(satInc(32'(stallCnt), 32'(PERF_MAX), stall));
      mduStallCnt <= PERF_W'(satInc(32'(mduStallCnt), 32'(PERF_MAX),
                                    sbStall && !lwStall && !brStall));
    end
  end

  assign hz.Pending     = pending;
  assign hz.StallCnt    = stallCnt;
  assign hz.MduStallCnt = mduStallCnt;
endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench: combinational vector table plus multi-cycle scoreboard / counter sequences.
module tb_hazard_scoreboard_unit;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  hazard_scoreboard_unit_if #(.NREG(32), .PERF_W(4)) hif ();
  hazard_scoreboard_unit #(.NREG(32), .MDU_MAX(4), .PERF_W(4)) dut (
    .clk(clk), .reset(reset), .hz(hif));

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] rsD, rtD, rsE, rtE, wrE, wrM, wrW;
    logic       rwE, rwM, rwW, mtrE, mtrM, brD;
    logic [1:0] fae, fbe;
    logic       fad, fbd, st;
  } vec_t;
  vec_t tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    hif.RsD = 0; hif.RtD = 0; hif.WriteRegD = 0; hif.RsE = 0; hif.RtE = 0;
    hif.WriteRegE = 0; hif.WriteRegM = 0; hif.WriteRegW = 0; hif.MduDoneReg = 0;
    hif.RegWriteD = 0; hif.RegWriteE = 0; hif.RegWriteM = 0; hif.RegWriteW = 0;
    hif.MemtoRegE = 0; hif.MemtoRegM = 0; hif.BranchD = 0; hif.MduIssueD = 0; hif.MduDone = 0;
  endtask

  task automatic edge1();
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    reset = 1'b1; idle(); edge1(); reset = 1'b0;
  endtask

  task automatic issue(input logic [4:0] r);
    hif.MduIssueD = 1; hif.RegWriteD = 1; hif.WriteRegD = r;
  endtask

  function automatic logic [2:0] stl();
    return {hif.StallF, hif.StallD, hif.FlushE};
  endfunction

  initial begin
    // rsD rtD rsE rtE wrE wrM wrW  rwE rwM rwW mtrE mtrM brD  fae fbe fad fbd st
    tbl[0]  = '{5'd0,5'd0,5'd3,5'd0,5'd0,5'd3,5'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b10,2'b00,1'b0,1'b0,1'b0};
    tbl[1]  = '{5'd0,5'd0,5'd3,5'd0,5'd0,5'd3,5'd3, 1'b0,1'b0,1'b1,1'b0,1'b0,1'b0, 2'b01,2'b00,1'b0,1'b0,1'b0};
    tbl[2]  = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd3,5'd3, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b0,1'b0,1'b0};
    tbl[3]  = '{5'd0,5'd0,5'd0,5'd7,5'd0,5'd7,5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b10,1'b0,1'b0,1'b0};
    tbl[4]  = '{5'd0,5'd0,5'd0,5'd7,5'd0,5'd6,5'd7, 1'b0,1'b1,1'b1,1'b0,1'b0,1'b0, 2'b00,2'b01,1'b0,1'b0,1'b0};
    tbl[5]  = '{5'd4,5'd6,5'd0,5'd0,5'd0,5'd4,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b1,1'b0,1'b0};
    tbl[6]  = '{5'd5,5'd0,5'd0,5'd5,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00,1'b0,1'b0,1'b1};
    tbl[7]  = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b0,1'b0,1'b0,1'b1,1'b0,1'b0, 2'b00,2'b00,1'b0,1'b0,1'b0};
    tbl[8]  = '{5'd2,5'd0,5'd0,5'd0,5'd2,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,1'b0,1'b0,1'b1};
    tbl[9]  = '{5'd0,5'd9,5'd0,5'd0,5'd0,5'd9,5'd0, 1'b0,1'b1,1'b0,1'b0,1'b1,1'b1, 2'b00,2'b00,1'b0,1'b1,1'b1};
    tbl[10] = '{5'd0,5'd0,5'd0,5'd0,5'd0,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b1, 2'b00,2'b00,1'b0,1'b0,1'b0};
    tbl[11] = '{5'd2,5'd0,5'd0,5'd0,5'd2,5'd0,5'd0, 1'b1,1'b0,1'b0,1'b0,1'b0,1'b0, 2'b00,2'b00,1'b0,1'b0,1'b0};
    tbl[12] = '{5'd3,5'd0,5'd0,5'd0,5'd0,5'd3,5'd0, 1'b0,1'b0,1'b0,1'b0,1'b1,1'b1, 2'b00,2'b00,1'b0,1'b0,1'b1};

    idle();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("reset_fwd_stall", {hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD, stl()}, 0);
    chk("reset_pending", hif.Pending, 0);
    chk("reset_counters", {hif.StallCnt, hif.MduStallCnt}, 0);

    // Combinational forwarding / interlock table
    for (int i = 0; i < 13; i++) begin
      hif.RsD = tbl[i].rsD; hif.RtD = tbl[i].rtD; hif.RsE = tbl[i].rsE; hif.RtE = tbl[i].rtE;
      hif.WriteRegE = tbl[i].wrE; hif.WriteRegM = tbl[i].wrM; hif.WriteRegW = tbl[i].wrW;
      hif.RegWriteE = tbl[i].rwE; hif.RegWriteM = tbl[i].rwM; hif.RegWriteW = tbl[i].rwW;
      hif.MemtoRegE = tbl[i].mtrE; hif.MemtoRegM = tbl[i].mtrM; hif.BranchD = tbl[i].brD;
      #1;
      chk($sformatf("vec%0d", i),
          {hif.ForwardAE, hif.ForwardBE, hif.ForwardAD, hif.ForwardBD, stl()},
          {tbl[i].fae, tbl[i].fbe, tbl[i].fad, tbl[i].fbd, {3{tbl[i].st}}});
    end

    // Load-use: one stall cycle, counted once
    doReset();
    hif.MemtoRegE = 1; hif.RtE = 5; hif.RsD = 5; #1;
    chk("lu_stall", stl(), 3'b111);
    chk("lu_cnt0", hif.StallCnt, 0);
    edge1(); idle(); #1;
    chk("lu_release", stl(), 3'b000);
    chk("lu_cnt1", hif.StallCnt, 1);

    // MDU RAW on r8 held until MduDone r8
    doReset();
    issue(8); #1;
    chk("raw_issue_nostall", stl(), 3'b000);
    edge1();
    hif.MduIssueD = 0; hif.RegWriteD = 1; hif.WriteRegD = 10; hif.RsD = 8; #1;
    chk("raw_pending8", hif.Pending, 32'h0000_0100);
    chk("raw_stall", stl(), 3'b111);
    repeat (3) edge1();
    chk("raw_still_stall", stl(), 3'b111);
    chk("raw_mducnt", hif.MduStallCnt, 3);
    hif.MduDone = 1; hif.MduDoneReg = 8; #1;
    chk("raw_done_nostall", stl(), 3'b000);
    edge1(); idle(); #1;
    chk("raw_cleared", hif.Pending, 0);
    chk("raw_mducnt_hold", hif.MduStallCnt, 3);

    // Capacity limit with same-cycle completion
    doReset();
    for (int r = 1; r <= 4; r++) begin issue(5'(r)); edge1(); end
    issue(5); #1;
    chk("cap_pending", hif.Pending, 32'h0000_001E);
    chk("cap_stall", stl(), 3'b111);
    edge1();
    chk("cap_mducnt", hif.MduStallCnt, 1);
    hif.MduDone = 1; hif.MduDoneReg = 1; #1;
    chk("cap_done_nostall", stl(), 3'b000);
    edge1();
    hif.MduDone = 0; issue(6); #1;
    chk("cap_pending2", hif.Pending, 32'h0000_003C);
    chk("cap_still_full", stl(), 3'b111);

    // Set/clear collision, issue to r0, done on idle reg
    doReset();
    issue(9); edge1();
    hif.MduDone = 1; hif.MduDoneReg = 9; issue(9); #1;
    chk("col_nostall", stl(), 3'b000);
    edge1();
    hif.MduDone = 0; hif.MduIssueD = 1; hif.RegWriteD = 0; hif.WriteRegD = 0; #1;
    chk("col_set_wins", hif.Pending, 32'h0000_0200);
    edge1();
    chk("col_r0_ignored", hif.Pending, 32'h0000_0200);
    hif.MduIssueD = 0; hif.MduDone = 1; hif.MduDoneReg = 12;
    edge1(); idle(); #1;
    chk("col_done_idle", hif.Pending, 32'h0000_0200);

    // Reset mid-operation beats a same-cycle issue
    doReset();
    for (int r = 1; r <= 3; r++) begin issue(5'(r)); edge1(); end
    idle(); hif.RsD = 1; #1;
    chk("rst_stall_active", stl(), 3'b111);
    edge1();
    reset = 1'b1; hif.RsD = 0; issue(7);
    edge1();
    reset = 1'b0; idle(); #1;
    chk("rst_pending", hif.Pending, 0);
    chk("rst_counters", {hif.StallCnt, hif.MduStallCnt}, 0);
    chk("rst_stall", stl(), 3'b000);

    // Counter saturation at 4 bits
    hif.MemtoRegE = 1; hif.RtE = 5; hif.RsD = 5;
    repeat (20) edge1();
    chk("sat_stallcnt", hif.StallCnt, 15);
    chk("sat_mducnt_zero", hif.MduStallCnt, 0);
    idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
